// File: rtl/data_cache_fa_if.sv
// CPU-side request/response and backing-memory bus of the fully associative data cache.
// The cache is the slave; the CPU/memory environment is the master.
interface data_cache_fa_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              flush;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache_fa.sv
// Fully associative, write-through, no-write-allocate data cache with
// round-robin replacement and saturating hit/miss statistics.
//
// state   | meaning
// IDLE    | sample flush / cpu request, resolve hit or miss
// RD_MISS | refill request outstanding, wait for mem_ack
// WR_THRU | write-through request outstanding, wait for mem_ack
// DONE    | cpu_ready pulse, return to IDLE
module data_cache_fa #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int OFF_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    data_cache_fa_if.slave   bus,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o
);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic [IDX_W-1:0]    ptr_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [CNT_W-1:0]    hit_q;
    logic [CNT_W-1:0]    miss_q;

    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                free;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    victim;
    logic                accept;
    logic                wr_hit;
    logic                install;
    logic                unused_off_bits;

    // Byte offset never reaches the tag; the cpu address is held stable
    // until cpu_ready, so the refill tag is taken straight from it.
    assign req_tag         = bus.cpu_addr[ADDR_W-1:OFF_W];
    assign unused_off_bits = ^bus.cpu_addr[OFF_W-1:0];

    assign accept  = (state_q == IDLE) && !bus.flush && bus.cpu_req;
    assign wr_hit  = accept && bus.cpu_we && hit;
    assign install = (state_q == RD_MISS) && bus.mem_ack;

    // Tag lookup across all lines; at most one valid line can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim: lowest-index invalid line, else the round-robin pointer.
    always_comb begin
        free     = 1'b0;
        free_idx = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        victim = free ? free_idx : ptr_q;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.cpu_we) state_d = WR_THRU;
                    else if (hit)   state_d = DONE;
                    else            state_d = RD_MISS;
                end
            end
            RD_MISS: if (bus.mem_ack) state_d = DONE;
            WR_THRU: if (bus.mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready is a decode of DONE, everything else is registered.
    always_comb begin
        bus.cpu_ready = (state_q == DONE);
        bus.cpu_rdata = cpu_rdata_q;
        bus.mem_req   = mem_req_q;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        hit_count_o   = hit_q;
        miss_count_o  = miss_q;
    end

    // Control state: valid bits, pointer, memory request, read data, statistics.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q     <= '0;
            ptr_q       <= '0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                        ptr_q   <= '0;
                    end else if (bus.cpu_req) begin
                        if (hit) begin
                            if (hit_q != '1) hit_q <= hit_q + 1'b1;
                            if (!bus.cpu_we) cpu_rdata_q <= data_q[hit_idx];
                        end else if (miss_q != '1) begin
                            miss_q <= miss_q + 1'b1;
                        end
                        if (bus.cpu_we || !hit) begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= bus.cpu_we;
                            mem_addr_q <= {req_tag, {OFF_W{1'b0}}};
                        end
                        if (bus.cpu_we) mem_wdata_q <= bus.cpu_wdata;
                    end
                end
                RD_MISS: begin
                    if (bus.mem_ack) begin
                        mem_req_q       <= 1'b0;
                        valid_q[victim] <= 1'b1;
                        cpu_rdata_q     <= bus.mem_rdata;
                        // Filling an empty line leaves the rotation untouched.
                        if (!free) ptr_q <= ptr_q + 1'b1;
                    end
                end
                WR_THRU: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays: no reset needed, valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (wr_hit) begin
                data_q[hit_idx] <= bus.cpu_wdata;
            end else if (install) begin
                tag_q[victim]  <= req_tag;
                data_q[victim] <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_data_cache_fa.sv
// Bench for data_cache_fa: directed table, flush/reset corner sequences,
// randomized accesses against a line-level reference model, plus a second
// instance with 2-bit counters fed the same stimulus to exercise saturation.
module tb_data_cache_fa;
    localparam logic [31:0] K = 32'hA5A5A5A5;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] hc1, mc1;
    logic [1:0]  hc2, mc2;
    int vectors = 0;
    int errors  = 0;
    bit resp_en = 1'b1;
    int mcnt    = 0;

    data_cache_fa_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    data_cache_fa_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    data_cache_fa #(.ADDR_W(32), .DATA_W(32), .LINES(NL), .OFF_W(2), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave),
        .hit_count_o(hc1), .miss_count_o(mc1));

    data_cache_fa #(.ADDR_W(32), .DATA_W(32), .LINES(NL), .OFF_W(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus2.slave),
        .hit_count_o(hc2), .miss_count_o(mc2));

    assign bus2.cpu_req   = bus.cpu_req;
    assign bus2.cpu_we    = bus.cpu_we;
    assign bus2.cpu_addr  = bus.cpu_addr;
    assign bus2.cpu_wdata = bus.cpu_wdata;
    assign bus2.flush     = bus.flush;
    assign bus2.mem_ack   = bus.mem_ack;
    assign bus2.mem_rdata = bus.mem_rdata;

    always #5 clk = ~clk;

    // Backing memory: ack three cycles after the request, data = address ^ K.
    always @(negedge clk) begin
        if (resp_en) begin
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                mcnt = 0;
            end else if (bus.mem_req) begin
                mcnt++;
                if (mcnt == 3) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ K;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    bit          mv [NL];
    logic [29:0] mt [NL];
    logic [31:0] md [NL];
    int          mptr;
    int          mhit, mmiss;
    logic [31:0] mlast;

    function automatic void m_flush();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
        mptr = 0;
    endfunction

    function automatic void m_reset();
        m_flush();
        mhit = 0; mmiss = 0; mlast = '0;
    endfunction

    function automatic bit m_access(input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [29:0] tag;
        bit h;
        int idx, v;
        tag = a[31:2];
        h = 1'b0; idx = 0;
        for (int i = 0; i < NL; i++) if (mv[i] && mt[i] == tag) begin h = 1'b1; idx = i; end
        if (h) mhit = (mhit < 65535) ? mhit + 1 : mhit;
        else   mmiss = (mmiss < 65535) ? mmiss + 1 : mmiss;
        if (!we) begin
            if (h) mlast = md[idx];
            else begin
                mlast = {tag, 2'b00} ^ K;
                v = -1;
                for (int i = 0; i < NL; i++) if (!mv[i] && v < 0) v = i;
                if (v < 0) begin v = mptr; mptr = (mptr + 1) % NL; end
                mv[v] = 1'b1; mt[v] = tag; md[v] = mlast;
            end
        end else if (h) begin
            md[idx] = wd;
        end
        return h;
    endfunction

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit fl, output int lat, output logic [31:0] rd);
        bit done, saw, h;
        logic [31:0] maddr, mwdata, maddr2, mwdata2;
        bit mwe, mwe2;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.flush = fl;
        lat = 0; done = 1'b0; saw = 1'b0; rd = '0;
        maddr = '0; mwdata = '0; mwe = 1'b0; maddr2 = '0; mwdata2 = '0; mwe2 = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (fl && lat == 1) begin
                chk("flush_no_ready", bus.cpu_ready, 1'b0);
                bus.flush = 1'b0;
            end
            if (bus.mem_req) begin
                if (!saw) begin
                    saw = 1'b1;
                    maddr = bus.mem_addr; mwe = bus.mem_we; mwdata = bus.mem_wdata;
                    maddr2 = bus2.mem_addr; mwe2 = bus2.mem_we; mwdata2 = bus2.mem_wdata;
                end else begin
                    chk("mem_addr_stable", bus.mem_addr, maddr);
                end
            end
            if (bus.cpu_ready) begin
                done = 1'b1;
                rd = bus.cpu_rdata;
                chk("mem_req_dropped", bus.mem_req, 1'b0);
                chk("dut2_ready", bus2.cpu_ready, 1'b1);
                chk("dut2_mem_req", bus2.mem_req, 1'b0);
            end
        end
        bus.cpu_req = 1'b0;
        if (!done) begin
            vectors++; errors++;
            $display("FAIL ready_timeout: got no cpu_ready expected within 60 cycles");
        end
        if (fl) m_flush();
        h = m_access(we, addr, wd);
        chk("latency", lat, ((!we && h) ? 1 : 4) + (fl ? 1 : 0));
        chk("rdata", rd, mlast);
        chk("dut2_rdata", bus2.cpu_rdata, mlast);
        chk("mem_seen", saw, we || !h);
        if (we || !h) begin
            chk("mem_addr", maddr, {addr[31:2], 2'b00});
            chk("mem_we", mwe, we);
            chk("dut2_mem_addr", maddr2, {addr[31:2], 2'b00});
            chk("dut2_mem_we", mwe2, we);
            if (we) begin
                chk("mem_wdata", mwdata, wd);
                chk("dut2_mem_wdata", mwdata2, wd);
            end
        end
        chk("hit_count", hc1, mhit);
        chk("miss_count", mc1, mmiss);
        chk("hit_count_sat", hc2, sat3(mhit));
        chk("miss_count_sat", mc2, sat3(mmiss));
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_only_ready", bus.cpu_ready, 1'b0);
        bus.flush = 1'b0;
        m_flush();
    endtask

    typedef struct {
        int          op;      // 0 read, 1 write, 2 flush
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int lat;
        logic [31:0] rd;
        int r;

        tbl[0]  = '{0, 32'h100, 32'h0,        1'b0, 32'hA5A5A4A5};
        tbl[1]  = '{0, 32'h100, 32'h0,        1'b1, 32'hA5A5A4A5};
        tbl[2]  = '{2, 32'h0,   32'h0,        1'b0, 32'h0};
        tbl[3]  = '{0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[4]  = '{0, 32'h4,   32'h0,        1'b0, 32'hA5A5A5A1};
        tbl[5]  = '{0, 32'h8,   32'h0,        1'b0, 32'hA5A5A5AD};
        tbl[6]  = '{0, 32'hC,   32'h0,        1'b0, 32'hA5A5A5A9};
        tbl[7]  = '{0, 32'h10,  32'h0,        1'b0, 32'hA5A5A5B5};
        tbl[8]  = '{0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[9]  = '{0, 32'h4,   32'h0,        1'b0, 32'hA5A5A5A1};
        tbl[10] = '{0, 32'h10,  32'h0,        1'b1, 32'hA5A5A5B5};
        tbl[11] = '{1, 32'h4,   32'hDEADBEEF, 1'b1, 32'h0};
        tbl[12] = '{0, 32'h4,   32'h0,        1'b1, 32'hDEADBEEF};
        tbl[13] = '{1, 32'h40,  32'h12345678, 1'b0, 32'h0};
        tbl[14] = '{0, 32'h40,  32'h0,        1'b0, 32'hA5A5A5E5};
        tbl[15] = '{0, 32'hC,   32'h0,        1'b0, 32'hA5A5A5A9};
        tbl[16] = '{0, 32'h8,   32'h0,        1'b0, 32'hA5A5A5AD};
        tbl[17] = '{0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[18] = '{0, 32'h40,  32'h0,        1'b1, 32'hA5A5A5E5};

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        m_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_hit_count", hc1, 16'h0);
        chk("rst_miss_count", mc1, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: cold/warm reads, eviction order, write-through.
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].op == 2) begin
                do_flush();
            end else begin
                access(tbl[i].op == 1, tbl[i].addr, tbl[i].wdata, 1'b0, lat, rd);
                if (tbl[i].op == 0) begin
                    chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
                    chk($sformatf("tbl%0d_hit", i), lat == 1, tbl[i].exp_hit);
                end
            end
        end

        // Flush together with a request on a cached line: served afterwards as a miss.
        access(1'b0, 32'h40, 32'h0, 1'b1, lat, rd);
        chk("flush_req_latency", lat, 5);
        chk("flush_req_rdata", rd, 32'hA5A5A5E5);

        // Reset during a refill, followed by a stray ack.
        resp_en = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200;
        @(posedge clk); #1;
        chk("midmiss_mem_req", bus.mem_req, 1'b1);
        rst_n = 1'b0; bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("midmiss_rst_mem_req", bus.mem_req, 1'b0);
        chk("midmiss_rst_ready", bus.cpu_ready, 1'b0);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        chk("stray_ack_ready0", bus.cpu_ready, 1'b0);
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("stray_ack_ready1", bus.cpu_ready, 1'b0);
        chk("stray_hit_count", hc1, 16'h0);
        chk("stray_miss_count", mc1, 16'h0);
        m_reset();
        mcnt = 0;
        resp_en = 1'b1;

        // 0x200 must miss (nothing installed), then five hits saturate dut2 at 3.
        access(1'b0, 32'h200, 32'h0, 1'b0, lat, rd);
        chk("post_rst_miss", lat, 4);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, 32'h200, 32'h0, 1'b0, lat, rd);
        end
        chk("sat_hit_count", hc2, 2'd3);

        // Randomized traffic over a small tag pool to force evictions.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 1) ? 24'h0 : 24'h1, 6'($urandom_range(0, 7) * 8 / 2), 2'($urandom_range(0, 3))};
            r = $urandom_range(0, 99);
            if (r < 5) do_flush();
            else if (r < 40) access(1'b1, a, $urandom, r < 8, lat, rd);
            else access(1'b0, a, 32'h0, r > 96, lat, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/data_cache_fa.md
DATA_CACHE_FA -- requirements
Module: data_cache_fa

Interface
REQ-001 Parameter ADDR_W, 32, byte address width.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter LINES, 16, number of lines; power of two, >=2.
REQ-004 Parameter OFF_W, 2, byte-offset bits dropped from the tag; tag = cpu_addr[ADDR_W-1:OFF_W].
REQ-005 Parameter CNT_W, 16, statistics counter width.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset; synchronous and active-low.
REQ-008 cpu_req  input  1  access request; held with all cpu_* inputs stable until cpu_ready.
REQ-009 cpu_we  input  1  1 = write, 0 = read.
REQ-010 cpu_addr  input  ADDR_W  byte address (ALU result).
REQ-011 cpu_wdata  input  DATA_W  write data.
REQ-012 cpu_rdata  output  DATA_W  read data, registered, valid while cpu_ready=1.
REQ-013 cpu_ready  output  1  one-cycle completion pulse.
REQ-014 flush  input  1  invalidate all lines.
REQ-015 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-016 mem_we  output  1  backing-memory write strobe.
REQ-017 mem_addr  output  ADDR_W  word address = {tag, OFF_W zeros}.
REQ-018 mem_wdata  output  DATA_W  write-through data.
REQ-019 mem_rdata  input  DATA_W  refill data, valid with mem_ack.
REQ-020 mem_ack  input  1  one-cycle completion from memory.
REQ-021 hit_count, miss_count  output  CNT_W each  saturating statistics.

Function
REQ-022 Fully associative: LINES entries of {valid, tag, data}; hit = any valid entry whose tag equals the request tag. At most one entry matches.
REQ-023 FSM states: IDLE, RD_MISS, WR_THRU, DONE. Requests and flush are sampled only in IDLE.
REQ-024 IDLE, flush=1: all valid bits clear, replacement pointer -> 0, stay IDLE, no cpu_ready. flush takes priority over a same-cycle cpu_req.
REQ-025 IDLE, read hit: cpu_rdata <= line data, hit_count +1, -> DONE. Latency 1 cycle.
REQ-026 IDLE, read miss: miss_count +1, -> RD_MISS; mem_req=1, mem_we=0, mem_addr driven from the next cycle.
REQ-027 RD_MISS on mem_ack: install {1, tag, mem_rdata} into the victim, cpu_rdata <= mem_rdata, -> DONE.
REQ-028 Victim selection: lowest-index invalid line if one exists; otherwise the line at the round-robin pointer, which then advances by 1 mod LINES. The pointer does not move when an invalid line is filled.
REQ-029 IDLE, write: write-through, no-write-allocate.
REQ-030 Write hit: update the line data in the same cycle, hit_count +1.
REQ-031 Write miss: leave the cache unchanged, miss_count +1.
REQ-032 Both write cases: -> WR_THRU with mem_req=1, mem_we=1, mem_wdata=cpu_wdata.
REQ-033 WR_THRU on mem_ack: -> DONE.
REQ-034 DONE: cpu_ready=1 for exactly one cycle, -> IDLE. The earliest next request is accepted the following cycle.
REQ-035 mem_req, mem_we, mem_addr and mem_wdata are registered and stay constant from assertion until the mem_ack cycle. mem_req drops the cycle after mem_ack.
REQ-036 mem_ack outside RD_MISS/WR_THRU is ignored.
REQ-037 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-038 cpu_rdata holds its last value outside DONE.

Reset
REQ-039 rst_n=0 at an edge, in any state including mid-miss:
- state -> IDLE
- all valid bits 0, pointer 0
- cpu_ready=0, mem_req=0, mem_we=0
- cpu_rdata, mem_addr, mem_wdata = 0
- both counters 0
REQ-040 Tag and data arrays need no reset. An outstanding memory transaction is abandoned; its later mem_ack is ignored per REQ-036.

Verification (LINES=4, OFF_W=2, memory returns data = address XOR 32'hA5A5A5A5 after 3 cycles)
REQ-041 Cold read 0x100 -> mem_req with mem_addr=0x100, then cpu_rdata=0xA5A5A4A5 with cpu_ready; a repeat read of 0x100 -> cpu_ready 1 cycle after request, no mem_req, hit_count=1, miss_count=1.
REQ-042 Read 0x0,0x4,0x8,0xC, then 0x10, then 0x0 -> 0x10 evicts line 0 (pointer 0->1); the read of 0x0 misses again and evicts line 1 (address 0x4).
REQ-043 Write 0xDEADBEEF to cached 0x4 -> mem_we=1, mem_addr=0x4; a following read of 0x4 hits, returning 0xDEADBEEF. Write to uncached 0x40 -> no allocate; a read of 0x40 misses.
REQ-044 flush asserted together with cpu_req in IDLE -> no cpu_ready that cycle; the request is then served after flush drops, as a miss.
REQ-045 rst_n=0 during RD_MISS before mem_ack -> mem_req=0 next edge; the stray mem_ack causes no install and no cpu_ready.
REQ-046 CNT_W=2: five read hits -> hit_count holds 3.
